// File: rtl/pixel_frame_source.sv
// rtl/pixel_frame_source.sv - raster-scan synthetic frame source with three colour markers
//
// Streams one frame per accepted request, one pixel per clock in raster order,
// followed by a fixed idle gap and a one-cycle frame_done pulse.
// Every frame is a flat background with three square markers whose centres are
// captured when the request is accepted.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   frame_req            pulse: start one frame (ignored while busy)
//   abort                terminate the current frame on the next edge
//   mx0..mx2, my0..my2   marker centres, captured on an accepted frame_req
//   pixel_r/g/b          signed 12-bit pixel colour
//   pixel_valid          pixel and coordinates valid this cycle
//   x, y                 coordinates of the current pixel
//   busy                 frame in progress (active or blanking)
//   frame_done           one-cycle pulse on the last blanking cycle
//   frame_cnt            completed frames, wraps at 16 bits
module pixel_frame_source #(
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int BLOB         = 4,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_req,
    input  logic                          abort,
    input  logic [$clog2(IMG_WIDTH)-1:0]  mx0,
    input  logic [$clog2(IMG_WIDTH)-1:0]  mx1,
    input  logic [$clog2(IMG_WIDTH)-1:0]  mx2,
    input  logic [$clog2(IMG_HEIGHT)-1:0] my0,
    input  logic [$clog2(IMG_HEIGHT)-1:0] my1,
    input  logic [$clog2(IMG_HEIGHT)-1:0] my2,
    output logic signed [11:0]            pixel_r,
    output logic signed [11:0]            pixel_g,
    output logic signed [11:0]            pixel_b,
    output logic                          pixel_valid,
    output logic [$clog2(IMG_WIDTH)-1:0]  x,
    output logic [$clog2(IMG_HEIGHT)-1:0] y,
    output logic                          busy,
    output logic                          frame_done,
    output logic [15:0]                   frame_cnt
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int BW = $clog2(BLANK_CYCLES + 1);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [BW-1:0] B_LAST = BW'(BLANK_CYCLES);
    localparam logic [BW-1:0] B_ONE  = BW'(1);

    // Blob bounds relative to the centre: [c - LO, c + HI]. Kept signed and one
    // bit wider than the coordinate so markers near an edge clip instead of wrap.
    localparam logic signed [XW:0] LO_X = (XW+1)'(BLOB / 2);
    localparam logic signed [XW:0] HI_X = (XW+1)'(BLOB / 2 - 1);
    localparam logic signed [YW:0] LO_Y = (YW+1)'(BLOB / 2);
    localparam logic signed [YW:0] HI_Y = (YW+1)'(BLOB / 2 - 1);

    localparam logic signed [11:0] K0_R = 12'sd50,  K0_G = 12'sd100, K0_B = 12'sd150;
    localparam logic signed [11:0] K1_R = 12'sd450, K1_G = 12'sd500, K1_B = 12'sd550;
    localparam logic signed [11:0] K2_R = 12'sd900, K2_G = 12'sd950, K2_B = 12'sd1000;
    localparam logic signed [11:0] BG   = 12'sd300;

    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

    state_t         state;
    logic [XW-1:0]  lmx0, lmx1, lmx2;
    logic [YW-1:0]  lmy0, lmy1, lmy2;
    logic [BW-1:0]  blank_cnt;

    // Coordinates and marker set of the pixel that will be presented next cycle.
    logic [XW-1:0]  nx;
    logic [YW-1:0]  ny;
    logic [XW-1:0]  smx0, smx1, smx2;
    logic [YW-1:0]  smy0, smy1, smy2;
    logic           hit0, hit1, hit2;
    logic signed [11:0] col_r, col_g, col_b;

    function automatic logic in_span_x(input logic [XW-1:0] p, input logic [XW-1:0] c);
        logic signed [XW:0] ps;
        logic signed [XW:0] cs;
        ps = signed'({1'b0, p});
        cs = signed'({1'b0, c});
        return (ps >= cs - LO_X) && (ps <= cs + HI_X);
    endfunction

    function automatic logic in_span_y(input logic [YW-1:0] p, input logic [YW-1:0] c);
        logic signed [YW:0] ps;
        logic signed [YW:0] cs;
        ps = signed'({1'b0, p});
        cs = signed'({1'b0, c});
        return (ps >= cs - LO_Y) && (ps <= cs + HI_Y);
    endfunction

    always_comb begin
        nx   = '0;
        ny   = '0;
        smx0 = lmx0; smx1 = lmx1; smx2 = lmx2;
        smy0 = lmy0; smy1 = lmy1; smy2 = lmy2;
        if (state == IDLE) begin
            // First pixel of a new frame uses the positions being captured now.
            smx0 = mx0; smx1 = mx1; smx2 = mx2;
            smy0 = my0; smy1 = my1; smy2 = my2;
        end else if (x == X_LAST) begin
            ny = y + Y_ONE;
        end else begin
            nx = x + X_ONE;
            ny = y;
        end

        hit0 = in_span_x(nx, smx0) && in_span_y(ny, smy0);
        hit1 = in_span_x(nx, smx1) && in_span_y(ny, smy1);
        hit2 = in_span_x(nx, smx2) && in_span_y(ny, smy2);

        col_r = BG; col_g = BG; col_b = BG;
        if (hit0) begin
            col_r = K0_R; col_g = K0_G; col_b = K0_B;
        end else if (hit1) begin
            col_r = K1_R; col_g = K1_G; col_b = K1_B;
        end else if (hit2) begin
            col_r = K2_R; col_g = K2_G; col_b = K2_B;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lmx0 <= '0; lmx1 <= '0; lmx2 <= '0;
            lmy0 <= '0; lmy1 <= '0; lmy2 <= '0;
            blank_cnt   <= '0;
            pixel_r     <= '0;
            pixel_g     <= '0;
            pixel_b     <= '0;
            pixel_valid <= 1'b0;
            x           <= '0;
            y           <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_req && !abort) begin
                        lmx0 <= mx0; lmx1 <= mx1; lmx2 <= mx2;
                        lmy0 <= my0; lmy1 <= my1; lmy2 <= my2;
                        state       <= ACTIVE;
                        busy        <= 1'b1;
                        pixel_valid <= 1'b1;
                        x           <= '0;
                        y           <= '0;
                        pixel_r     <= col_r;
                        pixel_g     <= col_g;
                        pixel_b     <= col_b;
                    end
                end
                ACTIVE: begin
                    if (abort) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        pixel_valid <= 1'b0;
                        x           <= '0;
                        y           <= '0;
                        pixel_r     <= '0;
                        pixel_g     <= '0;
                        pixel_b     <= '0;
                    end else if (x == X_LAST && y == Y_LAST) begin
                        state       <= BLANK;
                        blank_cnt   <= B_ONE;
                        pixel_valid <= 1'b0;
                        x           <= '0;
                        y           <= '0;
                        pixel_r     <= '0;
                        pixel_g     <= '0;
                        pixel_b     <= '0;
                        // A single blanking cycle is also the frame_done cycle.
                        if (BLANK_CYCLES == 1) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                        end
                    end else begin
                        x       <= nx;
                        y       <= ny;
                        pixel_r <= col_r;
                        pixel_g <= col_g;
                        pixel_b <= col_b;
                    end
                end
                BLANK: begin
                    if (abort || blank_cnt == B_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        blank_cnt <= blank_cnt + B_ONE;
                        if (blank_cnt + B_ONE == B_LAST) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
